// File: rtl/out_sig_compactor.sv
// Folds each accepted DUT output beat into a 32-bit MISR over a programmable window
// and presents the resulting signature and beat count on a valid/ready handshake.
module out_sig_compactor #(
  parameter int unsigned      DATA_W = 330,
  parameter int unsigned      SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED   = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              start,
  input  logic [15:0]       win_len,
  output logic              busy,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [SIG_W-1:0]  sig,
  output logic [15:0]       sig_count
);

  localparam int unsigned NumWords = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int unsigned PadW     = NumWords * SIG_W;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [SIG_W-1:0] misr_q, misr_next;
  logic [SIG_W-1:0] fold_q, fold;
  logic             fold_v_q;
  logic [15:0]      cnt_q, cnt_inc, len_q;
  logic             accept;
  logic [PadW-1:0]  padded;

  // Zero-pad to a whole number of words and XOR-reduce; aliasing of p and p+32k is intended.
  always_comb begin
    padded = '0;
    padded[DATA_W-1:0] = in_data;
    fold = '0;
    for (int unsigned i = 0; i < NumWords; i++) begin
      fold = fold ^ padded[i*SIG_W +: SIG_W];
    end
  end

  assign misr_next = {misr_q[SIG_W-2:0], 1'b0} ^ (misr_q[SIG_W-1] ? POLY : '0) ^ fold_q;
  assign cnt_inc   = cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (win_len != 16'd0) ? StRun : StDrain;
        end
      end
      StRun: begin
        if (in_valid) begin
          accept = 1'b1;
          if (cnt_inc == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: state_d = StDone;
      StDone: begin
        if (sig_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      misr_q   <= '0;
      fold_q   <= '0;
      fold_v_q <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      fold_v_q <= accept;
      if (state_q == StIdle && start) begin
        misr_q <= SEED;
        cnt_q  <= '0;
        len_q  <= win_len;
      end else if (fold_v_q) begin
        misr_q <= misr_next;
      end
      if (accept) begin
        fold_q <= fold;
        cnt_q  <= cnt_inc;
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign sig_valid = (state_q == StDone);
  assign sig       = misr_q;
  assign sig_count = cnt_q;

endmodule

// File: tb/tb_out_sig_compactor.sv
// Randomized self-checking bench for out_sig_compactor against a queue-based signature model.
module tb_out_sig_compactor;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [329:0] in_data = '0;
  logic         start = 1'b0;
  logic [15:0]  win_len = '0;
  logic         busy, sig_valid;
  logic         sig_ready = 1'b0;
  logic [31:0]  sig;
  logic [15:0]  sig_count;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] lcg = 32'd1667823855;
  logic [329:0] beats[$];

  always #5 clk = ~clk;

  out_sig_compactor dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .start     (start),
    .win_len   (win_len),
    .busy      (busy),
    .sig_valid (sig_valid),
    .sig_ready (sig_ready),
    .sig       (sig),
    .sig_count (sig_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit p of the beat lands on signature bit p mod 32.
  function automatic logic [31:0] model_sig(input int n);
    logic [31:0] m, f;
    m = SEED;
    for (int b = 0; b < n; b++) begin
      f = '0;
      for (int p = 0; p < 330; p++) f[p % 32] = f[p % 32] ^ beats[b][p];
      m = {m[30:0], 1'b0} ^ (m[31] ? POLY : 32'h0) ^ f;
    end
    return m;
  endfunction

  function automatic logic [329:0] rand_beat();
    logic [351:0] w;
    for (int i = 0; i < 11; i++) w[i*32 +: 32] = $urandom();
    return w[329:0];
  endfunction

  task automatic lcg_beat(output logic [329:0] d);
    logic [351:0] w;
    for (int i = 0; i < 11; i++) begin
      lcg = lcg * 32'd1664525 + 32'd1013904223;
      w[i*32 +: 32] = lcg;
    end
    d = w[329:0];
  endtask

  task automatic do_start(input logic [15:0] len);
    start   = 1'b1;
    win_len = len;
    step();
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
  endtask

  task automatic handshake();
    sig_ready = 1'b1;
    step();
    sig_ready = 1'b0;
    check_eq("valid_after_hs", sig_valid, 0);
    check_eq("busy_after_hs", busy, 0);
  endtask

  // One-beat window with a fixed expected signature.
  task automatic run_single(input string tag, input logic [329:0] d, input logic [31:0] exp);
    do_start(16'd1);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    check_eq({tag, "_drain_valid"}, sig_valid, 0);
    step();
    check_eq({tag, "_valid"}, sig_valid, 1);
    check_eq({tag, "_sig"}, sig, exp);
    check_eq({tag, "_count"}, sig_count, 1);
    handshake();
  endtask

  initial begin
    logic [329:0] d;
    int           got, len, cyc;
    logic [31:0]  exp_sig;
    logic         pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    void'($urandom(32'd1667823855));
    step();
    step();
    rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", sig_valid, 0);
    check_eq("rst_sig", sig, 0);
    check_eq("rst_count", sig_count, 0);

    run_single("zero", '0, 32'hFB3EE249);
    run_single("bit0", 330'd1, 32'hFB3EE248);
    d = '0;
    d[320] = 1'b1;
    run_single("bit320", d, 32'hFB3EE248);

    // Zero-length window: beats offered throughout must be ignored.
    in_valid = 1'b1;
    in_data  = rand_beat();
    do_start(16'd0);
    check_eq("wl0_drain_valid", sig_valid, 0);
    in_data = rand_beat();
    step();
    in_valid = 1'b0;
    check_eq("wl0_valid", sig_valid, 1);
    check_eq("wl0_sig", sig, SEED);
    check_eq("wl0_count", sig_count, 0);
    handshake();

    // Gapped beats, then a stalled consumer; start alongside the handshake is not accepted.
    beats.delete();
    do_start(16'd3);
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      in_data  = rand_beat();
      if (pat[i]) beats.push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    check_eq("gap_drain_valid", sig_valid, 0);
    step();
    exp_sig = model_sig(3);
    for (int i = 0; i < 5; i++) begin
      check_eq("gap_stall_valid", sig_valid, 1);
      check_eq("gap_stall_sig", sig, exp_sig);
      check_eq("gap_stall_count", sig_count, 3);
      step();
    end
    start   = 1'b1;
    win_len = 16'd1;
    handshake();
    start = 1'b0;
    step();
    check_eq("hs_start_ignored", busy, 0);

    // Reset in the middle of a window.
    do_start(16'd4);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = rand_beat();
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_valid", sig_valid, 0);
    check_eq("mid_rst_sig", sig, 0);
    check_eq("mid_rst_count", sig_count, 0);
    run_single("post_rst", '0, 32'hFB3EE249);

    // Long LCG window with continuous beats and stray start pulses while busy.
    beats.delete();
    do_start(16'd300);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      lcg_beat(d);
      in_data = d;
      beats.push_back(d);
      start   = ($urandom_range(0, 7) == 0);
      win_len = 16'($urandom_range(0, 9));
      step();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check_eq("lcg_drain_valid", sig_valid, 0);
    step();
    check_eq("lcg_valid", sig_valid, 1);
    check_eq("lcg_sig", sig, model_sig(300));
    check_eq("lcg_count", sig_count, 300);
    handshake();

    // Random back-to-back windows with random gaps and consumer delays.
    for (int w = 0; w < 6; w++) begin
      beats.delete();
      len = $urandom_range(1, 20);
      got = 0;
      cyc = 0;
      do_start(16'(len));
      while (got < len && cyc < 500) begin
        in_valid = $urandom_range(0, 1);
        in_data  = rand_beat();
        if (in_valid) begin
          beats.push_back(in_data);
          got++;
        end
        step();
        cyc++;
      end
      check_eq("rnd_beats_in_budget", got, len);
      in_valid = 1'b1;
      in_data  = rand_beat();
      check_eq("rnd_drain_valid", sig_valid, 0);
      step();
      check_eq("rnd_valid", sig_valid, 1);
      check_eq("rnd_sig", sig, model_sig(len));
      check_eq("rnd_count", sig_count, 64'(len));
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
      in_valid = 1'b0;
      handshake();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
